// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage: XORs each column-mixed state word with the round key
// for the current round, behind a one-deep valid/ready output register.
module add_round_key_stage #(
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_Key_We,
  input  logic [ADDR_W-1:0] i_Key_Addr,
  input  logic [127:0]      i_Key_Data,
  output logic              o_Key_Err,
  input  logic              i_Start,
  output logic              o_Busy,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [127:0]      i_Data,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [127:0]      o_Data,
  output logic [ADDR_W-1:0] o_Round,
  output logic              o_Last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_RND = ADDR_W'(NR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [127:0]      key_q [0:NR];
  logic [127:0]      key_d [0:NR];
  logic              valid_q, valid_d;
  logic [127:0]      data_q, data_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic              last_q, last_d;
  logic              key_err_q, key_err_d;

  logic              ready;
  logic              accept;
  logic              key_wr_ok;
  logic [127:0]      round_key;

  // The output register can take a new word when empty or when it drains
  // this same cycle, so a held word never blocks a steady stream.
  always_comb begin
    ready     = (state_q == S_RUN) && (!valid_q || i_Ready);
    accept    = i_Valid && ready;
    key_wr_ok = i_Key_We && (state_q == S_IDLE) && (i_Key_Addr <= LAST_RND);
    round_key = key_q[cnt_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (cnt_q == LAST_RND) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    round_d = round_q;
    last_d  = last_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = i_Data ^ round_key;
      round_d = cnt_q;
      last_d  = (cnt_q == LAST_RND);
    end else if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end
  end

  // Writes are only legal while no block is in flight; anything else is
  // dropped and reported so the key-schedule side can retry.
  always_comb begin
    key_err_d = i_Key_We && !key_wr_ok;
    for (int i = 0; i <= NR; i++) begin
      key_d[i] = key_q[i];
    end
    if (key_wr_ok) begin
      key_d[i_Key_Addr] = i_Key_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      round_q   <= '0;
      last_q    <= 1'b0;
      key_err_q <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      round_q   <= round_d;
      last_q    <= last_d;
      key_err_q <= key_err_d;
      for (int i = 0; i <= NR; i++) begin
        key_q[i] <= key_d[i];
      end
    end
  end

  always_comb begin
    o_Ready   = ready;
    o_Busy    = (state_q == S_RUN);
    o_Valid   = valid_q;
    o_Data    = data_q;
    o_Round   = round_q;
    o_Last    = last_q;
    o_Key_Err = key_err_q;
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: directed AES vectors, corner sequences and
// randomized blocks checked against a cycle-level behavioural model.
module tb_add_round_key_stage;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_Key_We;
  logic [3:0]   i_Key_Addr;
  logic [127:0] i_Key_Data;
  logic         o_Key_Err;
  logic         i_Start;
  logic         o_Busy;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Data;
  logic         o_Valid;
  logic         i_Ready;
  logic [127:0] o_Data;
  logic [3:0]   o_Round;
  logic         o_Last;

  add_round_key_stage #(.NR(NR), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Key_We(i_Key_We), .i_Key_Addr(i_Key_Addr), .i_Key_Data(i_Key_Data),
    .o_Key_Err(o_Key_Err), .i_Start(i_Start), .o_Busy(o_Busy),
    .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Data(i_Data),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data),
    .o_Round(o_Round), .o_Last(o_Last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the key store contents plus what the output should show.
  logic [127:0] m_key [0:NR];
  logic         m_run;
  logic [3:0]   m_cnt;
  logic         m_valid;
  logic [127:0] m_data;
  logic [3:0]   m_rnd;
  logic         m_last;
  logic         m_err;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [0:1];

  task automatic chk_d(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= NR; i++) m_key[i] = '0;
    m_run = 1'b0; m_cnt = '0; m_valid = 1'b0;
    m_data = '0; m_rnd = '0; m_last = 1'b0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    i_Key_We = 1'b0; i_Key_Addr = '0; i_Key_Data = '0;
    i_Start = 1'b0; i_Valid = 1'b0; i_Data = '0; i_Ready = 1'b1;
  endtask

  // One clock with the currently driven inputs: checks the combinational
  // outputs before the edge, advances the model, checks registered outputs.
  task automatic cycle();
    logic exp_ready, acc, wr_ok, st;
    #1;
    exp_ready = m_run && (!m_valid || i_Ready);
    chk_b("o_Ready", o_Ready, exp_ready);
    chk_b("o_Busy", o_Busy, m_run);
    acc   = i_Valid && exp_ready;
    wr_ok = i_Key_We && !m_run && (i_Key_Addr <= 4'(NR));
    st    = i_Start && !m_run;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_err = i_Key_We && !wr_ok;
      if (acc) begin
        m_data  = i_Data ^ m_key[m_cnt];
        m_rnd   = m_cnt;
        m_last  = (m_cnt == 4'(NR));
        m_valid = 1'b1;
        $display("accept round %0d in %h out %h", m_cnt, i_Data, m_data);
        if (m_cnt == 4'(NR)) begin
          m_cnt = '0;
          m_run = 1'b0;
        end else begin
          m_cnt = m_cnt + 4'd1;
        end
      end else if (m_valid && i_Ready) begin
        m_valid = 1'b0;
      end
      if (st) begin
        m_run = 1'b1;
        m_cnt = '0;
      end
      if (wr_ok) m_key[i_Key_Addr] = i_Key_Data;
    end
    #1;
    chk_b("o_Valid", o_Valid, m_valid);
    chk_d("o_Data", o_Data, m_data);
    chk_r("o_Round", o_Round, m_rnd);
    chk_b("o_Last", o_Last, m_last);
    chk_b("o_Key_Err", o_Key_Err, m_err);
  endtask

  task automatic write_key(input logic [3:0] addr, input logic [127:0] key);
    i_Key_We = 1'b1; i_Key_Addr = addr; i_Key_Data = key;
    cycle();
    i_Key_We = 1'b0;
  endtask

  task automatic start_block();
    i_Start = 1'b1;
    cycle();
    i_Start = 1'b0;
  endtask

  // Random valid/ready traffic (plus ignored starts and illegal key writes)
  // until the block completes and its last word has drained.
  task automatic finish_block(input int budget);
    int n = 0;
    while ((m_run || m_valid) && n < budget) begin
      i_Valid    = ($urandom_range(0, 3) != 0);
      i_Ready    = ($urandom_range(0, 3) != 0);
      i_Data     = {$urandom, $urandom, $urandom, $urandom};
      i_Start    = m_run && ($urandom_range(0, 7) == 0);
      i_Key_We   = m_run && ($urandom_range(0, 15) == 0);
      i_Key_Addr = 4'($urandom_range(0, 15));
      i_Key_Data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      n++;
    end
    checks++;
    if (m_run || m_valid) begin
      errors++;
      $display("FAIL finish_block: block still open after %0d cycles, expected done", n);
    end
    idle_inputs();
  endtask

  initial begin
    logic [127:0] held;
    logic [7:0]   rb;
    int           n;

    vecs[0] = '{4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[1] = '{4'd1, 128'ha0fafe1788542cb123a339392a6c7605,
                128'h046681e5e0cb199a48f8d37a2806264c, 128'ha49c7ff2689f352b6b5bea43026a5049};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset o_Valid", o_Valid, 1'b0);
    chk_b("reset o_Busy", o_Busy, 1'b0);
    chk_b("reset o_Ready", o_Ready, 1'b0);
    chk_d("reset o_Data", o_Data, '0);
    chk_r("reset o_Round", o_Round, '0);
    chk_b("reset o_Last", o_Last, 1'b0);
    chk_b("reset o_Key_Err", o_Key_Err, 1'b0);
    rst_n = 1'b1;

    // AES reference vectors from a table.
    for (int i = 0; i < 2; i++) write_key(vecs[i].addr, vecs[i].key);
    start_block();
    for (int i = 0; i < 2; i++) begin
      i_Valid = 1'b1; i_Data = vecs[i].data; i_Ready = 1'b1;
      cycle();
      chk_d("aes o_Data", o_Data, vecs[i].exp);
      chk_r("aes o_Round", o_Round, 4'(i));
      chk_b("aes o_Last", o_Last, 1'b0);
    end
    idle_inputs();
    finish_block(200);

    // Full block back to back: k_r = r in every byte, zero input.
    for (int r = 0; r <= NR; r++) begin
      rb = 8'(r);
      write_key(4'(r), {16{rb}});
    end
    start_block();
    i_Valid = 1'b1; i_Data = '0; i_Ready = 1'b1;
    for (int r = 0; r <= NR; r++) begin
      rb = 8'(r);
      cycle();
      chk_d("full o_Data", o_Data, {16{rb}});
      chk_r("full o_Round", o_Round, 4'(r));
      chk_b("full o_Last", o_Last, (r == NR));
    end
    #1;
    chk_b("full busy after last", o_Busy, 1'b0);
    chk_b("full ready after last", o_Ready, 1'b0);
    cycle();
    idle_inputs();
    cycle();

    // Backpressure: three stalled cycles, then drain and accept together.
    start_block();
    i_Valid = 1'b1; i_Data = 128'h0123456789abcdef0011223344556677; i_Ready = 1'b1;
    cycle();
    held = o_Data;
    i_Data = 128'hfedcba98765432100f1e2d3c4b5a6978; i_Ready = 1'b0;
    repeat (3) begin
      cycle();
      chk_d("stall o_Data held", o_Data, held);
      chk_r("stall o_Round held", o_Round, 4'd0);
    end
    i_Ready = 1'b1;
    cycle();
    chk_r("no bubble o_Round", o_Round, 4'd1);
    chk_d("no bubble o_Data", o_Data, 128'hfedcba98765432100f1e2d3c4b5a6978 ^ {16{8'h01}});
    idle_inputs();
    finish_block(200);

    // Rejected key writes, then rerun round 3 with the unchanged key.
    start_block();
    write_key(4'd3, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    chk_b("run write err", o_Key_Err, 1'b1);
    cycle();
    chk_b("err one pulse", o_Key_Err, 1'b0);
    finish_block(200);
    write_key(4'd12, 128'h5555aaaa5555aaaa5555aaaa5555aaaa);
    chk_b("addr>NR err", o_Key_Err, 1'b1);
    cycle();
    start_block();
    i_Ready = 1'b1; i_Data = '0;
    for (int r = 0; r <= 3; r++) begin
      i_Valid = 1'b1;
      cycle();
    end
    chk_d("round3 key kept", o_Data, {16{8'h03}});
    idle_inputs();
    finish_block(200);

    // Start with valid in IDLE: no accept; write with start: both honoured.
    i_Start = 1'b1; i_Valid = 1'b1; i_Data = '1;
    i_Key_We = 1'b1; i_Key_Addr = 4'd0; i_Key_Data = 128'h00112233445566778899aabbccddeeff;
    cycle();
    chk_b("start+valid no accept", o_Valid, 1'b0);
    idle_inputs();
    i_Valid = 1'b1; i_Data = '0;
    cycle();
    chk_d("write+start key used", o_Data, 128'h00112233445566778899aabbccddeeff);
    idle_inputs();
    finish_block(200);

    // Randomized blocks with fresh random keys.
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r <= NR; r++)
        if ($urandom_range(0, 1) == 1)
          write_key(4'(r), {$urandom, $urandom, $urandom, $urandom});
      start_block();
      finish_block(300);
      cycle();
    end

    // Reset in the middle of a block, while round 5 is held at the output.
    start_block();
    i_Valid = 1'b1; i_Ready = 1'b1;
    n = 0;
    while (!(m_valid && m_rnd == 4'd5) && n < 20) begin
      i_Data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      n++;
    end
    chk_r("reached round 5", o_Round, 4'd5);
    i_Ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk_b("mid reset o_Valid", o_Valid, 1'b0);
    chk_b("mid reset o_Busy", o_Busy, 1'b0);
    idle_inputs();
    start_block();
    i_Valid = 1'b1; i_Data = '0;
    for (int r = 0; r < 3; r++) begin
      cycle();
      chk_d("keys cleared", o_Data, '0);
    end
    idle_inputs();
    finish_block(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- AES AddRoundKey stage, directly downstream of mix_column.
- Consumes the 128-bit column-mixed state one round at a time and XORs it with the matching round key from an internal key store.
- The key store is loaded by the key-schedule side before a block starts.
- The result is registered behind a valid/ready handshake, tagged with the round index, and flagged on the final round.

Parameters:
NR, 10, number of rounds; the key store holds NR+1 round keys (addresses 0..NR)
ADDR_W, 4, width of key address and round index; must satisfy 2^ADDR_W > NR

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  synchronous active-low reset
i_Key_We  input  1  key store write enable
i_Key_Addr  input  ADDR_W  round-key index to write
i_Key_Data  input  128  round key, same byte order as i_Data
o_Key_Err  output  1  one-cycle pulse: rejected key write
i_Start  input  1  begin a new block at round 0
o_Busy  output  1  FSM in RUN
i_Valid  input  1  i_Data valid
o_Ready  output  1  stage accepts i_Data this cycle
i_Data  input  128  state from mix_column, bits 127:96 = column 0
o_Valid  output  1  o_Data valid
i_Ready  input  1  downstream accepts o_Data
o_Data  output  128  i_Data XOR key[round]
o_Round  output  ADDR_W  round index of o_Data
o_Last  output  1  o_Data belongs to round NR

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM to IDLE; round counter to 0; all key entries cleared to 0.
  - o_Valid, o_Last, o_Key_Err, o_Busy = 0; o_Data = 0; o_Round = 0.
  - Reset mid-block abandons the block; any held output is dropped.
- FSM states:
  - IDLE: i_Start=1 -> RUN, round counter = 0.
  - RUN: an accept while the counter equals NR -> IDLE.
  - i_Start is ignored in RUN.
  - o_Busy = (state==RUN).
- Handshake:
  - o_Ready = RUN && (!o_Valid || i_Ready); combinational, never depends on i_Valid.
  - Accept = i_Valid && o_Ready.
  - On accept, the next edge loads:
    - o_Data <= i_Data ^ key[counter]
    - o_Round <= counter
    - o_Last <= (counter==NR)
    - o_Valid <= 1
    - counter += 1, or cleared to 0 when it was NR.
  - Latency is 1 cycle. Throughput is 1 word/cycle when i_Ready is held high.
- Output hold:
  - If o_Valid && !i_Ready, then o_Data, o_Round and o_Last hold stable and no accept occurs.
  - If o_Valid && i_Ready and no accept, o_Valid drops to 0 next cycle.
  - A simultaneous drain and accept replaces the output with no bubble.
- IDLE: o_Ready=0; i_Valid is ignored. Start and valid in the same IDLE cycle: start takes effect, data is not accepted that cycle. A held final output may still drain in IDLE.
- Key writes:
  - A write is accepted only in IDLE with i_Key_Addr <= NR; key[addr] is updated at the edge.
  - A write in RUN, or with addr > NR, is ignored and pulses o_Key_Err for 1 cycle.
  - A key written in IDLE is visible to the next block; a write and i_Start in the same cycle are both honoured.
- Widths: pure 128-bit XOR, no carry; counter wraps only by explicit clear at NR.

Test Plan:
- Load key0=2b7e151628aed2a6abf7158809cf4f3c, start, i_Data=3243f6a8885a308d313198a2e0370734 -> next cycle o_Valid=1, o_Data=193de3bea0f4e22b9ac68d2ae9f84808, o_Round=0, o_Last=0.
- Load key1=a0fafe1788542cb123a339392a6c7605, second word 046681e5e0cb199a48f8d37a2806264c -> o_Data=a49c7ff2689f352b6b5bea43026a5049, o_Round=1.
- Full block, 11 back-to-back words with i_Ready=1 and keys k_r=r replicated per byte, inputs 0 -> outputs 0x00..0x0a patterns in 11 consecutive cycles; o_Last only on round 10; o_Busy falls after the 11th accept; o_Ready=0 afterwards.
- Backpressure: hold i_Ready=0 for 3 cycles with o_Valid=1 -> o_Data/o_Round unchanged, o_Ready=0, input not consumed; release -> the next word is accepted the same cycle with no bubble.
- Key write during RUN (addr 3), and in IDLE with addr 12 -> o_Key_Err pulses once each; store unchanged, verified by rerunning round 3.
- Assert rst_n=0 at round 5 with o_Valid=1 -> next cycle o_Valid=0, o_Busy=0, keys read back as 0 (block with zero input yields o_Data=0).
